// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate D-cache controller, one 64-bit word per line.
// Owns the data array and valid bits; the external tag array supplies hit/dirty/victim tag.
module dcache_ctrl #(
  parameter int unsigned TAG_LEN = 23,
  parameter int unsigned IDX_LEN = 6,
  parameter int unsigned TAG_NUM = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_valid_i,
  output logic               cpu_ready_o,
  input  logic [31:0]        cpu_addr_i,
  input  logic               cpu_we_i,
  input  logic [63:0]        cpu_wdata_i,
  input  logic [7:0]         cpu_wstrb_i,
  output logic               cpu_rvalid_o,
  output logic [63:0]        cpu_rdata_o,
  output logic [TAG_LEN-1:0] tag_o,
  output logic [IDX_LEN-1:0] index_o,
  output logic               tag_we_o,
  output logic               dirty_wr_o,
  input  logic               tag_hit_i,
  input  logic               dirty_i,
  input  logic [TAG_LEN-1:0] tag_rd_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [63:0]        mem_wdata_o,
  input  logic               mem_rvalid_i,
  input  logic [63:0]        mem_rdata_i
);

  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {IDLE, CMP, WB, RF, RF_WAIT} state_e;

  state_e               state_q, state_d;
  logic [31:3]          addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [SW-1:0]        wstrb_q, wstrb_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [TAG_NUM-1:0]   valid_q, valid_d;
  logic [DW-1:0]        data_q [TAG_NUM];

  logic [IDX_LEN-1:0]   index;
  logic [TAG_LEN-1:0]   tag;
  logic [DW-1:0]        line;
  logic [DW-1:0]        merged;
  logic                 hit;
  logic                 data_we;
  logic [DW-1:0]        data_wd;
  logic                 tag_we_c;
  logic                 dirty_wr_c;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr_i[2:0];

  assign index = addr_q[IDX_LEN+2:3];
  assign tag   = addr_q[31 -: TAG_LEN];
  assign line  = data_q[index];
  // The tag array resets to tag 0, so a tag match alone is not a hit.
  assign hit   = tag_hit_i & valid_q[index];

  always_comb begin
    merged = line;
    for (int b = 0; b < int'(SW); b++) begin
      if (wstrb_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    valid_d     = valid_q;
    data_we     = 1'b0;
    data_wd     = line;
    tag_we_c    = 1'b0;
    dirty_wr_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid_i && ready_q) begin
          addr_d  = cpu_addr_i[31:3];
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          wstrb_d = cpu_wstrb_i;
          state_d = CMP;
        end
      end
      CMP: begin
        if (hit) begin
          rvalid_d = 1'b1;
          state_d  = IDLE;
          if (we_q) begin
            data_we    = 1'b1;
            data_wd    = merged;
            tag_we_c   = 1'b1;
            dirty_wr_c = 1'b1;
          end else begin
            rdata_d = line;
          end
        end else if (valid_q[index] && dirty_i) begin
          // Victim address and data captured here so they stay stable through WB.
          state_d     = WB;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = 32'({tag_rd_i, index, 3'b000});
          mem_wdata_d = line;
        end else begin
          state_d     = RF;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'({tag, index, 3'b000});
        end
      end
      WB: begin
        if (mem_req_ready_i) begin
          state_d    = RF;
          mem_we_d   = 1'b0;
          mem_addr_d = 32'({tag, index, 3'b000});
        end
      end
      RF: begin
        if (mem_req_ready_i) begin
          state_d     = RF_WAIT;
          mem_valid_d = 1'b0;
        end
      end
      RF_WAIT: begin
        if (mem_rvalid_i) begin
          data_we        = 1'b1;
          data_wd        = mem_rdata_i;
          valid_d[index] = 1'b1;
          tag_we_c       = 1'b1;
          dirty_wr_c     = 1'b0;
          state_d        = CMP;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ready_q     <= 1'b1;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ready_q     <= ready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
    end
  end

  // Data array is not cleared by reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (rst_n && data_we) data_q[index] <= data_wd;
  end

  assign cpu_ready_o     = ready_q;
  assign cpu_rvalid_o    = rvalid_q;
  assign cpu_rdata_o     = rdata_q;
  assign tag_o           = tag;
  assign index_o         = index;
  assign tag_we_o        = tag_we_c;
  assign dirty_wr_o      = dirty_wr_c;
  assign mem_req_valid_o = mem_valid_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;

endmodule
